// File: rtl/adder_checker.sv
// In-circuit adder result checker: predicts a+b, compares against the sum one cycle later,
// counts results and logs failures. Define ADDER_CHECKER_TIMESTAMP_EN to stamp log entries.
module adder_checker #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned LOG_AW = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             halt_on_fail_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH:0]   sum_i,
  output logic             chk_valid_o,
  output logic             chk_pass_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic             err_sticky_o,
  output logic             halted_o,
  output logic             log_valid_o,
  input  logic             log_ready_i,
  output logic [WIDTH-1:0] log_a_o,
  output logic [WIDTH-1:0] log_b_o,
  output logic [WIDTH:0]   log_sum_o,
  output logic [WIDTH:0]   log_exp_o,
  output logic [31:0]      log_time_o,
  output logic             log_ovf_o
);

  localparam int unsigned Depth = 2 ** LOG_AW;
  localparam int unsigned PtrW  = LOG_AW + 1;

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] cap_a_q, cap_b_q;
  logic [WIDTH:0]   exp_q;
  logic             chk_valid_q, chk_valid_d;
  logic             chk_pass_q, chk_pass_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;

  logic             cap, do_cmp, fail, pop, push, full, empty;
  logic [LOG_AW-1:0] rd_idx, wr_idx;

  logic [WIDTH-1:0] mem_a   [Depth];
  logic [WIDTH-1:0] mem_b   [Depth];
  logic [WIDTH:0]   mem_sum [Depth];
  logic [WIDTH:0]   mem_exp [Depth];

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = ((wr_ptr_q - rd_ptr_q) == PtrW'(Depth));
  assign rd_idx = rd_ptr_q[LOG_AW-1:0];
  assign wr_idx = wr_ptr_q[LOG_AW-1:0];

  // clear overrides everything happening in the same cycle
  assign cap    = !clear_i && (state_q == StRun) && en_i;
  assign do_cmp = !clear_i && (state_q == StRun) && pend_q;
  assign fail   = do_cmp && (sum_i != exp_q);
  assign pop    = !clear_i && !empty && log_ready_i;
  assign push   = fail && (!full || pop);

  always_comb begin
    state_d     = state_q;
    pend_d      = cap && !(fail && halt_on_fail_i);
    chk_valid_d = do_cmp;
    chk_pass_d  = do_cmp && !fail;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (clear_i) begin
      state_d    = StRun;
      pass_cnt_d = '0;
      fail_cnt_d = '0;
      err_d      = 1'b0;
      ovf_d      = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (do_cmp && !fail && (pass_cnt_q != '1)) pass_cnt_d = pass_cnt_q + CNT_W'(1);
      if (fail) begin
        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
        err_d = 1'b1;
        if (!push) ovf_d = 1'b1;
        if (halt_on_fail_i) state_d = StHalted;
      end
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      pend_q      <= 1'b0;
      cap_a_q     <= '0;
      cap_b_q     <= '0;
      exp_q       <= '0;
      chk_valid_q <= 1'b0;
      chk_pass_q  <= 1'b0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      chk_valid_q <= chk_valid_d;
      chk_pass_q  <= chk_pass_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      if (cap) begin
        cap_a_q <= a_i;
        cap_b_q <= b_i;
        exp_q   <= {1'b0, a_i} + {1'b0, b_i};
      end
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_a[wr_idx]   <= cap_a_q;
      mem_b[wr_idx]   <= cap_b_q;
      mem_sum[wr_idx] <= sum_i;
      mem_exp[wr_idx] <= exp_q;
    end
  end

`ifdef ADDER_CHECKER_TIMESTAMP_EN
  logic [31:0] time_q;
  logic [31:0] mem_time [Depth];

  // Free-running; deliberately untouched by clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) time_q <= '0;
    else         time_q <= time_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_time[wr_idx] <= time_q;
  end

  assign log_time_o = empty ? '0 : mem_time[rd_idx];
`else
  assign log_time_o = '0;
`endif

  assign chk_valid_o  = chk_valid_q;
  assign chk_pass_o   = chk_pass_q;
  assign pass_cnt_o   = pass_cnt_q;
  assign fail_cnt_o   = fail_cnt_q;
  assign err_sticky_o = err_q;
  assign halted_o     = (state_q == StHalted);
  assign log_ovf_o    = ovf_q;
  assign log_valid_o  = !empty;
  assign log_a_o      = empty ? '0 : mem_a[rd_idx];
  assign log_b_o      = empty ? '0 : mem_b[rd_idx];
  assign log_sum_o    = empty ? '0 : mem_sum[rd_idx];
  assign log_exp_o    = empty ? '0 : mem_exp[rd_idx];

endmodule

// File: tb/tb_adder_checker.sv
// Bench for adder_checker: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a queue-based reference model.
module tb_adder_checker;

  localparam int W    = 8;
  localparam int CW   = 4;
  localparam int DEP  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          clear_i = 1'b0;
  logic          halt_on_fail_i = 1'b0;
  logic          en_i = 1'b0;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic [W:0]    sum_i = '0;
  logic          log_ready_i = 1'b0;
  logic          chk_valid_o, chk_pass_o, err_sticky_o, halted_o, log_valid_o, log_ovf_o;
  logic [CW-1:0] pass_cnt_o, fail_cnt_o;
  logic [W-1:0]  log_a_o, log_b_o;
  logic [W:0]    log_sum_o, log_exp_o;
  logic [31:0]   log_time_o;

  adder_checker #(.WIDTH(W), .CNT_W(CW), .LOG_AW(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .halt_on_fail_i (halt_on_fail_i),
    .en_i           (en_i),
    .a_i            (a_i),
    .b_i            (b_i),
    .sum_i          (sum_i),
    .chk_valid_o    (chk_valid_o),
    .chk_pass_o     (chk_pass_o),
    .pass_cnt_o     (pass_cnt_o),
    .fail_cnt_o     (fail_cnt_o),
    .err_sticky_o   (err_sticky_o),
    .halted_o       (halted_o),
    .log_valid_o    (log_valid_o),
    .log_ready_i    (log_ready_i),
    .log_a_o        (log_a_o),
    .log_b_o        (log_b_o),
    .log_sum_o      (log_sum_o),
    .log_exp_o      (log_exp_o),
    .log_time_o     (log_time_o),
    .log_ovf_o      (log_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one pending transaction, integer counters, queue of logged failures.
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   s;
    int           e;
    logic [31:0]  t;
  } ent_t;

  ent_t        logq[$];
  ent_t        ent;
  ent_t        head;
  int          m_pass = 0, m_fail = 0, p_exp = 0;
  bit          m_err = 0, m_halt = 0, m_ovf = 0, m_cv = 0, m_cp = 0;
  bit          p_have = 0, m_pop = 0, m_was_halted = 0;
  logic [W-1:0] p_a = '0, p_b = '0;
  logic [31:0] m_cyc = '0, m_stamp = '0;
  bit          chk_on = 0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_pass = 0; m_fail = 0; m_err = 0; m_halt = 0; m_ovf = 0; m_cv = 0; m_cp = 0;
      p_have = 0; m_cyc = '0;
      logq.delete();
    end else begin
      m_stamp = m_cyc;
      m_cyc   = m_cyc + 32'd1;
      m_cv    = 0;
      m_cp    = 0;
      if (clear_i) begin
        m_pass = 0; m_fail = 0; m_err = 0; m_halt = 0; m_ovf = 0; p_have = 0;
        logq.delete();
      end else begin
        m_pop        = (logq.size() != 0) && log_ready_i;
        m_was_halted = m_halt;
        if (m_pop) void'(logq.pop_front());
        if (!m_was_halted && p_have) begin
          m_cv = 1;
          m_cp = (int'(sum_i) == p_exp);
          if (m_cp) begin
            if (m_pass < CMAX) m_pass++;
          end else begin
            if (m_fail < CMAX) m_fail++;
            m_err = 1;
            if (logq.size() < DEP) begin
              ent.a = p_a; ent.b = p_b; ent.s = sum_i; ent.e = p_exp; ent.t = m_stamp;
              logq.push_back(ent);
            end else begin
              m_ovf = 1;
            end
            if (halt_on_fail_i) m_halt = 1;
          end
        end
        p_have = !m_halt && en_i;
        p_a    = a_i;
        p_b    = b_i;
        p_exp  = int'(a_i) + int'(b_i);
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_on) begin
      chk("chk_valid", chk_valid_o, m_cv);
      if (m_cv) chk("chk_pass", chk_pass_o, m_cp);
      chk("pass_cnt", pass_cnt_o, m_pass);
      chk("fail_cnt", fail_cnt_o, m_fail);
      chk("err_sticky", err_sticky_o, m_err);
      chk("halted", halted_o, m_halt);
      chk("log_ovf", log_ovf_o, m_ovf);
      chk("log_valid", log_valid_o, logq.size() != 0);
      if (logq.size() != 0) begin
        head = logq[0];
        chk("log_a", log_a_o, head.a);
        chk("log_b", log_b_o, head.b);
        chk("log_sum", log_sum_o, head.s);
        chk("log_exp", log_exp_o, head.e);
`ifdef ADDER_CHECKER_TIMESTAMP_EN
        chk("log_time", log_time_o, head.t);
`else
        chk("log_time", log_time_o, 0);
`endif
      end else begin
        chk("log_empty_zero", {log_a_o, log_b_o, log_sum_o, log_exp_o, log_time_o}, 0);
      end
    end
  end

  // Stimulus: sum presented in a cycle answers the transaction issued the cycle before.
  logic [W:0] nxt_sum = '0;

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drive(input logic e, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W:0] nsum);
    en_i    = e;
    a_i     = av;
    b_i     = bv;
    sum_i   = nxt_sum;
    nxt_sum = nsum;
    cyc();
  endtask

  function automatic logic [W:0] good(input logic [W-1:0] av, input logic [W-1:0] bv);
    return (W+1)'(int'(av) + int'(bv));
  endfunction

  function automatic logic [W:0] bad(input logic [W-1:0] av, input logic [W-1:0] bv);
    return good(av, bv) ^ ((W+1)'(1) << $urandom_range(0, W));
  endfunction

  task automatic pulse_clear();
    clear_i = 1'b1;
    drive(1'b0, '0, '0, '0);
    clear_i = 1'b0;
  endtask

  logic [W-1:0] sa[6];
  logic [W-1:0] sb[6];
  logic [W-1:0] ra, rb;
  logic [W:0]   rs;

  initial begin
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_chk_valid", chk_valid_o, 0);
    chk("rst_pass_cnt", pass_cnt_o, 0);
    chk("rst_log_valid", log_valid_o, 0);
    chk("rst_halted", halted_o, 0);
    chk_on = 1;
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;

    // Pass path
    drive(1'b1, 8'hFF, 8'h01, 9'h100);
    drive(1'b0, '0, '0, '0);
    chk("pass_valid", chk_valid_o, 1);
    chk("pass_result", chk_pass_o, 1);
    chk("pass_cnt1", pass_cnt_o, 1);
    chk("pass_nolog", log_valid_o, 0);

    // Fail path
    drive(1'b1, 8'h12, 8'h34, 9'h047);
    drive(1'b0, '0, '0, '0);
    chk("fail_result", chk_pass_o, 0);
    chk("fail_cnt1", fail_cnt_o, 1);
    chk("fail_err", err_sticky_o, 1);
    chk("fail_log_exp", log_exp_o, 9'h046);
    chk("fail_log_sum", log_sum_o, 9'h047);
    log_ready_i = 1'b1;
    cyc();
    log_ready_i = 1'b0;

    // Streaming failures into a full log
    pulse_clear();
    for (int i = 0; i < 6; i++) begin
      sa[i] = W'($urandom);
      sb[i] = W'($urandom);
      drive(1'b1, sa[i], sb[i], bad(sa[i], sb[i]));
    end
    drive(1'b0, '0, '0, '0);
    chk("ovf_fail_cnt", fail_cnt_o, 6);
    chk("ovf_flag", log_ovf_o, 1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_a", log_a_o, sa[i]);
      chk("drain_b", log_b_o, sb[i]);
      log_ready_i = 1'b1;
      cyc();
    end
    log_ready_i = 1'b0;
    chk("drain_empty", log_valid_o, 0);

    // Halt on first failure
    pulse_clear();
    halt_on_fail_i = 1'b1;
    drive(1'b1, 8'h20, 8'h30, 9'h051);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h01, 8'h02, 9'h003);
    drive(1'b0, '0, '0, '0);
    halt_on_fail_i = 1'b0;
    chk("halt_flag", halted_o, 1);
    chk("halt_pass_cnt", pass_cnt_o, 0);
    chk("halt_fail_cnt", fail_cnt_o, 1);
    pulse_clear();
    chk("clr_halted", halted_o, 0);
    chk("clr_fail_cnt", fail_cnt_o, 0);
    chk("clr_err", err_sticky_o, 0);
    chk("clr_log", log_valid_o, 0);

    // Saturation
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      drive(1'b1, ra, rb, good(ra, rb));
    end
    drive(1'b0, '0, '0, '0);
    chk("sat_pass_cnt", pass_cnt_o, 4'hF);
    drive(1'b1, 8'h05, 8'h06, 9'h00B);
    drive(1'b0, '0, '0, '0);
    chk("sat_hold", pass_cnt_o, 4'hF);

    // Async reset between capture and compare
    drive(1'b1, 8'h40, 8'h41, 9'h081);
    sum_i = nxt_sum;
    rst_ni = 1'b0;
    #1;
    chk("arst_cnt", pass_cnt_o, 0);
    chk("arst_valid", chk_valid_o, 0);
    #1 rst_ni = 1'b1;
    nxt_sum = '0;
    drive(1'b0, '0, '0, '0);
    chk("arst_no_check", chk_valid_o, 0);
    chk("arst_cnt_after", pass_cnt_o, 0);

    // clear coinciding with a pending failure
    drive(1'b1, 8'h11, 8'h22, 9'h034);
    drive(1'b0, '0, '0, '0);
    drive(1'b1, 8'h0A, 8'h0B, 9'h016);
    clear_i = 1'b1;
    drive(1'b0, '0, '0, '0);
    clear_i = 1'b0;
    chk("clrpri_valid", chk_valid_o, 0);
    chk("clrpri_fail_cnt", fail_cnt_o, 0);
    chk("clrpri_log", log_valid_o, 0);
    chk("clrpri_err", err_sticky_o, 0);

    // Randomized traffic checked against the model every cycle
    for (int i = 0; i < 1500; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? bad(ra, rb) : good(ra, rb);
      halt_on_fail_i = ($urandom_range(0, 19) == 0);
      log_ready_i    = 1'($urandom_range(0, 1));
      clear_i        = ($urandom_range(0, 49) == 0);
      drive(1'($urandom_range(0, 9) < 7), ra, rb, rs);
    end
    clear_i = 1'b0;
    drive(1'b0, '0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
